oled_frame_buffer: RTL

- Double-buffered monochrome pixel store feeding the i_PIXEL bitmap input of OLED_interface.
- Also drives that interface's i_START.
- Upstream logic (text renderer, switch demo) edits a back buffer pixel by pixel, then requests a commit.
- On commit, the block copies the back buffer to the stable front buffer only while the interface reports ready, then pulses start and tracks the transfer to completion.

---
 rtl/oled_frame_buffer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/oled_frame_buffer.sv
// oled_frame_buffer: double-buffered monochrome pixel store for OLED_interface.
// Upstream logic edits the back buffer and requests a commit. The block copies
// the back buffer to the front buffer (o_PIXEL) while the interface is ready,
// then pulses o_START and tracks the transfer.
// Optional feature: define OLED_FRAME_READBACK_EN to add a registered
// back-buffer read port (i_RD_COL, i_RD_ROW, o_RD_VAL).
module oled_frame_buffer #(
   parameter int NUM_COL     = 96,
   parameter int NUM_ROW     = 3,
   parameter int ACK_TIMEOUT = 4096
) (
   input  logic                                          i_CLK,
   input  logic                                          i_RST,
   input  logic                                          i_WR_EN,
   input  logic [$clog2(NUM_COL)-1:0]                    i_WR_COL,
   input  logic [$clog2((NUM_ROW > 1) ? NUM_ROW : 2)-1:0] i_WR_ROW,
   input  logic                                          i_WR_VAL,
   input  logic                                          i_CLEAR,
   input  logic                                          i_COMMIT,
   input  logic                                          i_READY,
`ifdef OLED_FRAME_READBACK_EN
   input  logic [$clog2(NUM_COL)-1:0]                    i_RD_COL,
   input  logic [$clog2((NUM_ROW > 1) ? NUM_ROW : 2)-1:0] i_RD_ROW,
   output logic                                          o_RD_VAL,
`endif
   output logic [NUM_COL*NUM_ROW-1:0]                    o_PIXEL,
   output logic                                          o_START,
   output logic                                          o_PENDING,
   output logic                                          o_BUSY,
   output logic                                          o_ERR
);

   localparam int NPIX  = NUM_COL * NUM_ROW;
   localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_ACK,
      ST_WAIT_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NPIX-1:0]  back_q, back_d;
   logic             copy;
   logic             ack_timeout;
   logic             wr_hit;
   logic [IDX_W-1:0] wr_idx;

   // Out-of-range addresses never touch the buffer.
   assign wr_hit = i_WR_EN && (int'(i_WR_COL) < NUM_COL) && (int'(i_WR_ROW) < NUM_ROW);
   assign wr_idx = IDX_W'(int'(i_WR_ROW) * NUM_COL + int'(i_WR_COL));

   // Back-buffer next value: clear first, then the single-pixel write on top.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      back_d = i_CLEAR ? '0 : back_q;
      if (wr_hit) back_d[wr_idx] = i_WR_VAL;
   end

   // Transfer FSM next-state logic; copy and timeout are one-cycle strobes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      copy        = 1'b0;
      ack_timeout = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (o_PENDING && i_READY) begin
               copy    = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            // The first WAIT_ACK cycle is the o_START cycle; the interface
            // gets ACK_TIMEOUT cycles from there to drop i_READY.
            if (!i_READY) begin
               state_d = ST_WAIT_DONE;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               ack_timeout = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (i_READY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and ack-timeout counter.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Back buffer storage.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      // NOTE: the pixel store is plain flops, so it is reset to a known blank frame; a RAM could not be.
      if (i_RST) back_q <= '0;
      else       back_q <= back_d;
   end

   // Front buffer and interface-facing flags. The front buffer only moves on
   // the copy edge, so it stays stable for the whole transfer; a new commit
   // on the copy cycle wins over the clear of o_PENDING.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         o_PIXEL   <= '0;
         o_START   <= 1'b0;
         o_PENDING <= 1'b0;
         o_ERR     <= 1'b0;
      end else begin
         if (copy) o_PIXEL <= back_q;
         o_START   <= (state_q == ST_START);
         o_PENDING <= i_COMMIT | ack_timeout | (o_PENDING & ~copy);
         o_ERR     <= o_ERR | ack_timeout;
      end
   end

   assign o_BUSY = (state_q != ST_IDLE);

`ifdef OLED_FRAME_READBACK_EN
   logic             rd_hit;
   logic [IDX_W-1:0] rd_idx;

   assign rd_hit = (int'(i_RD_COL) < NUM_COL) && (int'(i_RD_ROW) < NUM_ROW);
   assign rd_idx = IDX_W'(int'(i_RD_ROW) * NUM_COL + int'(i_RD_COL));

   // Registered readback of the pre-write back buffer; out of range reads 0.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) o_RD_VAL <= 1'b0;
      else       o_RD_VAL <= rd_hit & back_q[rd_idx];
   end
`endif

endmodule
